axis_pkt_gen: RTL and testbench

Parametrised AXI-Stream transmit packet generator that drives the MAC TX AXIS slave (`tx_axis_mac_*`) in bring-up and loopback benches. It generalises the fixed 64-bit stream master:
- data width is a parameter;
- packet length can be fixed, incrementing or pseudo-random;
- payload is incrementing-byte or LFSR;
- inter-frame gap is programmable, and `tuser` error frames can be injected periodically;
- packet and byte counters are exposed.

It is synthesisable and sits between the register block and the MAC TX AXIS port.

---
 rtl/axis_pkt_gen.sv | 269 ++++++++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// AXI-Stream transmit packet generator: fixed/incrementing/random lengths,
// incrementing-byte or LFSR payload, programmable gap and tuser error injection.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 14,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           cfg_pkt_count,
  input  logic [1:0]            cfg_len_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_len_min,
  input  logic [LEN_WIDTH-1:0]  cfg_len_max,
  input  logic                  cfg_pattern,
  input  logic [7:0]            cfg_ifg,
  input  logic [7:0]            cfg_err_every,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_sent,
  output logic [CNT_WIDTH-1:0]  byte_sent
);

  // Handshake: a beat transfers on m_axis_tvalid & m_axis_tready; once tvalid is
  // high the registered beat fields hold until that transfer; tvalid never looks at tready.

  localparam int OFF_W = LEN_WIDTH + 1;
  localparam logic [OFF_W-1:0] KEEP_L = OFF_W'(KEEP_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;
  state_t state;

  logic [31:0]          pkt_count_q;
  logic [1:0]           len_mode_q;
  logic [LEN_WIDTH-1:0] len_min_q, len_max_q;
  logic                 pattern_q;
  logic [7:0]           ifg_q, err_every_q;

  logic                 stop_pending;
  logic [LEN_WIDTH-1:0] cur_len;
  logic [OFF_W-1:0]     cur_off;
  logic [7:0]           seq;
  logic [31:0]          pay_lfsr;
  logic [15:0]          len_lfsr;
  logic [7:0]           err_phase, gap_cnt;
  logic [31:0]          pkt_num;

  function automatic logic [31:0] pay_adv(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [15:0] len_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic stop_any, hs, count_hit, run_end;
  assign stop_any  = stop_pending | stop;
  assign hs        = m_axis_tvalid & m_axis_tready;
  assign count_hit = (pkt_count_q != 32'd0) && (pkt_num + 32'd1 == pkt_count_q);
  assign run_end   = count_hit | stop_any;

  // Length of the next packet; in LOAD this yields the first packet's length.
  logic [LEN_WIDTH-1:0] span, mask, lfsr_bits, rnd, nxt_len;
  logic [LEN_WIDTH:0]   rsum;
  logic [15:0]          len_src;
  logic                 first;
  always_comb begin
    first   = (state == S_LOAD);
    len_src = first ? 16'hACE1 : len_lfsr;
    span    = len_max_q - len_min_q;
    mask    = span;
    for (int i = 1; i < LEN_WIDTH; i = i * 2) mask = mask | (mask >> i);
    lfsr_bits = '0;
    for (int i = 0; i < LEN_WIDTH && i < 16; i++) lfsr_bits[i] = len_src[i];
    rnd  = lfsr_bits & mask;
    rsum = {1'b0, len_min_q} + {1'b0, rnd};
    if (rsum > {1'b0, len_max_q}) rsum = rsum - ({1'b0, span} + 1'b1);
    case (len_mode_q)
      2'd1:    nxt_len = (first || cur_len >= len_max_q) ? len_min_q : cur_len + 1'b1;
      2'd2:    nxt_len = rsum[LEN_WIDTH-1:0];
      default: nxt_len = len_min_q;
    endcase
  end

  logic [7:0] err_phase_nxt;
  logic       err_cur, err_nxt;
  assign err_phase_nxt = (err_phase >= err_every_q) ? 8'd1 : err_phase + 8'd1;
  assign err_cur = (err_every_q != 8'd0) && (err_phase == err_every_q);
  assign err_nxt = (err_every_q != 8'd0) && (err_phase_nxt == err_every_q);

  // Select which beat to present next, then build it.
  logic [LEN_WIDTH-1:0]  b_len;
  logic [OFF_W-1:0]      b_off, rem;
  logic [7:0]            b_seq, b_byte;
  logic [31:0]           b_lfsr;
  logic                  b_err, b_last, b_user, beat_load;
  logic [DATA_WIDTH-1:0] b_data;
  logic [KEEP_WIDTH-1:0] b_keep;
  always_comb begin
    beat_load = 1'b0;
    b_len  = nxt_len;
    b_off  = '0;
    b_seq  = seq + 8'd1;
    b_lfsr = pay_adv(pay_lfsr);
    b_err  = err_nxt;
    case (state)
      S_LOAD: begin
        beat_load = !stop_any;
        b_seq     = 8'd0;
        b_lfsr    = 32'hFFFF_FFFF;
        b_err     = (err_every_q == 8'd1);
      end
      S_GAP: begin
        beat_load = !stop_any && gap_cnt == 8'd0;
        b_len     = cur_len;
        b_seq     = seq;
        b_lfsr    = pay_lfsr;
        b_err     = err_cur;
      end
      S_SEND: begin
        if (!m_axis_tlast) begin
          beat_load = hs;
          b_len     = cur_len;
          b_off     = cur_off + KEEP_L;
          b_seq     = seq;
          b_err     = err_cur;
        end else begin
          beat_load = hs && !run_end && ifg_q == 8'd0;
        end
      end
      default: ;
    endcase

    rem    = {1'b0, b_len} - b_off;
    b_last = (rem <= KEEP_L);
    b_user = b_last & b_err;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      b_keep[i] = !b_last || (OFF_W'(i) < rem);
      b_byte    = pattern_q ? b_lfsr[8*(i%4) +: 8] : b_seq + 8'(b_off) + 8'(i);
      b_data[8*i +: 8] = b_keep[i] ? b_byte : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      pkt_count_q   <= '0;
      len_mode_q    <= '0;
      len_min_q     <= '0;
      len_max_q     <= '0;
      pattern_q     <= 1'b0;
      ifg_q         <= '0;
      err_every_q   <= '0;
      stop_pending  <= 1'b0;
      cur_len       <= '0;
      cur_off       <= '0;
      seq           <= '0;
      pay_lfsr      <= '0;
      len_lfsr      <= '0;
      err_phase     <= '0;
      gap_cnt       <= '0;
      pkt_num       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_sent      <= '0;
      byte_sent     <= '0;
    end else begin
      done <= 1'b0;
      if (beat_load) begin
        m_axis_tdata <= b_data;
        m_axis_tkeep <= b_keep;
        m_axis_tlast <= b_last;
        m_axis_tuser <= b_user;
      end
      case (state)
        S_IDLE: begin
          stop_pending <= start & stop;
          if (start) begin
            pkt_count_q <= cfg_pkt_count;
            len_mode_q  <= cfg_len_mode;
            len_min_q   <= cfg_len_min;
            len_max_q   <= (cfg_len_max < cfg_len_min) ? cfg_len_min : cfg_len_max;
            pattern_q   <= cfg_pattern;
            ifg_q       <= cfg_ifg;
            err_every_q <= cfg_err_every;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          stop_pending <= stop_any;
          pkt_sent     <= '0;
          byte_sent    <= '0;
          pkt_num      <= '0;
          seq          <= '0;
          pay_lfsr     <= 32'hFFFF_FFFF;
          len_lfsr     <= len_adv(16'hACE1);
          cur_len      <= nxt_len;
          cur_off      <= '0;
          err_phase    <= 8'd1;
          if (stop_any) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            m_axis_tvalid <= 1'b1;
            state         <= S_SEND;
          end
        end
        S_SEND: begin
          stop_pending <= stop_any;
          if (hs) begin
            pay_lfsr <= pay_adv(pay_lfsr);
            if (!m_axis_tlast) begin
              cur_off <= cur_off + KEEP_L;
            end else begin
              pkt_sent  <= pkt_sent + 1'b1;
              byte_sent <= byte_sent + CNT_WIDTH'(cur_len);
              pkt_num   <= pkt_num + 32'd1;
              seq       <= seq + 8'd1;
              cur_len   <= nxt_len;
              len_lfsr  <= len_adv(len_lfsr);
              err_phase <= err_phase_nxt;
              cur_off   <= '0;
              if (run_end) begin
                m_axis_tvalid <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
                state         <= S_IDLE;
              end else if (ifg_q != 8'd0) begin
                m_axis_tvalid <= 1'b0;
                gap_cnt       <= ifg_q - 8'd1;
                state         <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          stop_pending <= stop_any;
          if (stop_any) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (gap_cnt == 8'd0) begin
            m_axis_tvalid <= 1'b1;
            state         <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed-plus-random bench for axis_pkt_gen: a packet-level reference model
// fills an expected beat queue that the AXIS sink drains and compares.
module tb_axis_pkt_gen;

  localparam int DW  = 64;
  localparam int KW  = DW / 8;
  localparam int LW  = 14;
  localparam int SBW = DW + KW + 2;

  logic          clk, reset, start, stop;
  logic [31:0]   cfg_pkt_count;
  logic [1:0]    cfg_len_mode;
  logic [LW-1:0] cfg_len_min, cfg_len_max;
  logic          cfg_pattern;
  logic [7:0]    cfg_ifg, cfg_err_every;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic          busy, done;
  logic [31:0]   pkt_sent, byte_sent;

  axis_pkt_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_pkt_count(cfg_pkt_count), .cfg_len_mode(cfg_len_mode),
    .cfg_len_min(cfg_len_min), .cfg_len_max(cfg_len_max),
    .cfg_pattern(cfg_pattern), .cfg_ifg(cfg_ifg), .cfg_err_every(cfg_err_every),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .pkt_sent(pkt_sent), .byte_sent(byte_sent)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [SBW-1:0] exp_q[$];
  longint exp_bytes;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: expected beat stream for n_pkts packets of one run.
  task automatic build_model(input int n_pkts, input int mode, input int lmin, input int lmax,
                             input bit pat, input int err_every);
    int maxe, span, mask, len, nbeats, idx;
    logic [15:0]   l16;
    logic [31:0]   p32;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    bit            last, usr;
    exp_q.delete();
    exp_bytes = 0;
    maxe = (lmax < lmin) ? lmin : lmax;
    span = maxe - lmin;
    mask = 0;
    while (mask < span) mask = mask * 2 + 1;
    l16 = 16'hACE1;
    p32 = 32'hFFFF_FFFF;
    for (int n = 1; n <= n_pkts; n++) begin
      case (mode)
        1: len = lmin + (n - 1) % (span + 1);
        2: begin
          len = lmin + (int'(l16[LW-1:0]) & mask);
          if (len > maxe) len = len - (span + 1);
        end
        default: len = lmin;
      endcase
      l16 = {l16[14:0], l16[15] ^ l16[13] ^ l16[12] ^ l16[10]};
      nbeats = (len + KW - 1) / KW;
      for (int b = 0; b < nbeats; b++) begin
        d = '0;
        k = '0;
        for (int i = 0; i < KW; i++) begin
          idx = b * KW + i;
          if (idx < len) begin
            k[i] = 1'b1;
            d[8*i +: 8] = pat ? p32[8*(i%4) +: 8] : 8'((n - 1 + idx) % 256);
          end
        end
        last = (b == nbeats - 1);
        usr  = last && err_every != 0 && (n % err_every) == 0;
        exp_q.push_back({usr, last, k, d});
        p32 = {p32[30:0], p32[31] ^ p32[21] ^ p32[1] ^ p32[0]};
      end
      exp_bytes += len;
    end
  endtask

  // Driver + sink for one run; stop is pulsed while beat stop_beat of packet stop_pkt is shown.
  task automatic run(input int cnt, input int mode, input int lmin, input int lmax, input bit pat,
                     input int ifg, input int err_every, input int ready_pct, input int n_model,
                     input int stop_pkt, input int stop_beat);
    logic [SBW-1:0] cur, held, e;
    bit  fin, first, stall_prev, in_gap, done_due;
    int  gap_cnt, pkt_no, beat_in, budget;
    build_model(n_model, mode, lmin, lmax, pat, err_every);
    @(negedge clk);
    cfg_pkt_count = cnt;
    cfg_len_mode  = 2'(mode);
    cfg_len_min   = LW'(lmin);
    cfg_len_max   = LW'(lmax);
    cfg_pattern   = pat;
    cfg_ifg       = 8'(ifg);
    cfg_err_every = 8'(err_every);
    start = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_tvalid", m_axis_tvalid, 0);
    fin = 0; first = 1; stall_prev = 0; in_gap = 0; done_due = 0;
    gap_cnt = 0; pkt_no = 1; beat_in = 1; budget = 4000;
    held = '0;
    while (!fin && budget > 0) begin
      @(negedge clk);
      budget--;
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (first) begin
        chk("start_latency", m_axis_tvalid, 1);
        first = 0;
      end
      if (done_due) begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("tvalid_at_done", m_axis_tvalid, 0);
        fin = 1;
      end else begin
        chk("no_early_done", done, 0);
        if (stall_prev) begin
          chk("stall_valid", m_axis_tvalid, 1);
          chk("stall_hold", cur, held);
        end
        if (in_gap) begin
          if (!m_axis_tvalid) gap_cnt++;
          else begin
            chk("ifg_len", gap_cnt, ifg);
            in_gap = 0;
          end
        end
        stop = m_axis_tvalid && pkt_no == stop_pkt && beat_in == stop_beat;
        m_axis_tready = ($urandom_range(99) < ready_pct);
        if (m_axis_tvalid && m_axis_tready) begin
          n_vec++;
          assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL extra_beat: observed %0h expected no beat", cur);
            fin = 1;
          end
          if (!fin) begin
            e = exp_q.pop_front();
            chk("beat", cur, e);
            if (e[SBW-2]) begin
              pkt_no++;
              beat_in = 1;
              if (exp_q.size() == 0) done_due = 1;
              else begin
                in_gap = 1;
                gap_cnt = 0;
              end
            end else begin
              beat_in++;
            end
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        held = cur;
      end
    end
    n_vec++;
    assert (fin) else begin
      n_err++;
      $error("FAIL run_timeout: observed %0d beats left expected 0", exp_q.size());
    end
    stop = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("pkt_sent", pkt_sent, n_model);
    chk("byte_sent", byte_sent, 32'(exp_bytes));
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int rmin, rmax;
    reset = 1'b1; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b0;
    cfg_pkt_count = '0; cfg_len_mode = '0; cfg_len_min = '0; cfg_len_max = '0;
    cfg_pattern = 1'b0; cfg_ifg = '0; cfg_err_every = '0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_outputs", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
    chk("rst_status", {busy, done, pkt_sent, byte_sent}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // fixed 64 bytes, back-to-back, full throughput
    run(3, 0, 64, 64, 0, 0, 0, 100, 3, -1, 0);
    // partial last beat
    run(1, 0, 61, 61, 0, 0, 0, 100, 1, -1, 0);
    // backpressure with a 5-cycle gap
    run(3, 0, 64, 64, 0, 5, 0, 50, 3, -1, 0);
    // incrementing length with every 2nd packet flagged
    run(4, 1, 60, 62, 0, 0, 2, 100, 4, -1, 0);
    // continuous mode stopped during beat 3 of packet 5
    run(0, 0, 64, 64, 0, 0, 0, 100, 5, 5, 3);
    // max below min collapses to min; mode 3 acts as fixed
    run(3, 1, 20, 5, 0, 1, 0, 80, 3, -1, 0);
    run(2, 3, 13, 90, 1, 0, 3, 60, 2, -1, 0);
    // random lengths with LFSR payload and random config
    for (int t = 0; t < 3; t++) begin
      rmin = $urandom_range(1, 40);
      rmax = rmin + $urandom_range(0, 120);
      run(6, 2, rmin, rmax, 1, $urandom_range(0, 3), $urandom_range(0, 3), 70, 6, -1, 0);
    end

    // start together with stop: LOAD then straight back to IDLE
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_load_busy", busy, 1);
    @(negedge clk);
    chk("ss_done", done, 1);
    chk("ss_busy", busy, 0);
    chk("ss_tvalid", m_axis_tvalid, 0);
    chk("ss_pkt_sent", pkt_sent, 0);
    @(negedge clk);
    chk("ss_done_drop", done, 0);

    // reset mid-packet drops tvalid/busy without a clock edge
    cfg_pkt_count = 32'd3; cfg_len_mode = 2'd0; cfg_len_min = LW'(64); cfg_len_max = LW'(64);
    cfg_pattern = 1'b0; cfg_ifg = 8'd0; cfg_err_every = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_axis_tready = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tvalid", m_axis_tvalid, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    chk("rst_counters", {pkt_sent, byte_sent}, 0);
    reset = 1'b0;
    m_axis_tready = 1'b0;
    run(3, 0, 64, 64, 0, 0, 0, 100, 3, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "global timeout");
  end

endmodule
